// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Brief    : Opcode names, FSM states and load-size decoding for wb_stage.
// Revision : 1.0
// ============================================================================
package wb_pkg;

    localparam logic [95:0] c_op_lb    = {80'h0, "lb"};
    localparam logic [95:0] c_op_lbu   = {72'h0, "lbu"};
    localparam logic [95:0] c_op_lh    = {80'h0, "lh"};
    localparam logic [95:0] c_op_lhu   = {72'h0, "lhu"};
    localparam logic [95:0] c_op_lw    = {80'h0, "lw"};
    localparam logic [95:0] c_op_lwu   = {72'h0, "lwu"};
    localparam logic [95:0] c_op_ld    = {80'h0, "ld"};
    localparam logic [95:0] c_op_ecall = {56'h0, "ecall"};

    localparam logic [4:0]  c_a0_regno = 5'd10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SYS_WAIT = 2'd1,
        SYS_RET  = 2'd2
    } wb_state_t;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_t;

    typedef struct packed {
        ld_size_t size;
        logic     is_signed;
    } ld_info_t;

    // Unknown names flagged as loads fall back to a full doubleword.
    function automatic ld_info_t decode_load(input logic [95:0] op);
        ld_info_t info;
        info.size      = LD_D;
        info.is_signed = 1'b0;
        case (op)
            c_op_lb:  begin info.size = LD_B; info.is_signed = 1'b1; end
            c_op_lbu: begin info.size = LD_B; info.is_signed = 1'b0; end
            c_op_lh:  begin info.size = LD_H; info.is_signed = 1'b1; end
            c_op_lhu: begin info.size = LD_H; info.is_signed = 1'b0; end
            c_op_lw:  begin info.size = LD_W; info.is_signed = 1'b1; end
            c_op_lwu: begin info.size = LD_W; info.is_signed = 1'b0; end
            default:  begin info.size = LD_D; info.is_signed = 1'b0; end
        endcase
        return info;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_if
// Brief    : Memory-stage, register-file and syscall-handler bundle for wb_stage.
// Revision : 1.0
// ============================================================================
interface wb_stage_if #(
    parameter int REGISTER_WIDTH         = 64,
    parameter int REGISTERNO_WIDTH       = 5,
    parameter int INSTRUCTION_NAME_WIDTH = 96
);
    logic                              in_enable;
    logic                              out_ready;
    logic [REGISTER_WIDTH-1:0]         in_alu_result;
    logic [REGISTER_WIDTH-1:0]         in_mdata;
    logic [REGISTERNO_WIDTH-1:0]       in_rd_regno;
    logic                              in_update_rd_bool;
    logic                              in_mm_load_bool;
    logic [INSTRUCTION_NAME_WIDTH-1:0] in_opcode_name;
    logic                              out_wr_en;
    logic [REGISTERNO_WIDTH-1:0]       out_wr_regno;
    logic [REGISTER_WIDTH-1:0]         out_wr_data;
    logic                              out_misaligned;
    logic                              out_syscall_req;
    logic                              in_syscall_done;
    logic [REGISTER_WIDTH-1:0]         in_syscall_ret;
    logic                              out_syscall_flush;
    logic [REGISTER_WIDTH-1:0]         out_retire_count;

    modport slave (
        input  in_enable, in_alu_result, in_mdata, in_rd_regno, in_update_rd_bool,
               in_mm_load_bool, in_opcode_name, in_syscall_done, in_syscall_ret,
        output out_ready, out_wr_en, out_wr_regno, out_wr_data, out_misaligned,
               out_syscall_req, out_syscall_flush, out_retire_count
    );

    modport master (
        output in_enable, in_alu_result, in_mdata, in_rd_regno, in_update_rd_bool,
               in_mm_load_bool, in_opcode_name, in_syscall_done, in_syscall_ret,
        input  out_ready, out_wr_en, out_wr_regno, out_wr_data, out_misaligned,
               out_syscall_req, out_syscall_flush, out_retire_count
    );
endinterface
`default_nettype wire

// File: rtl/wb_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Brief    : Selects and extends a load lane from an aligned doubleword.
// Revision : 1.0
// ============================================================================
module load_align
    import wb_pkg::*;
(
    input  wire ld_size_t    i_size,
    input  wire logic        i_signed,
    input  wire logic [2:0]  i_off,
    input  wire logic [63:0] i_data,
    output logic      [63:0] o_data,
    output logic             o_misaligned
);

    logic [63:0] w_shifted;

    // Misaligned accesses drop the low offset bits and still return a lane.
    always_comb begin
        w_shifted    = 64'h0;
        o_data       = 64'h0;
        o_misaligned = 1'b0;
        case (i_size)
            LD_B: begin
                w_shifted = i_data >> {i_off, 3'b000};
                o_data    = {{56{i_signed & w_shifted[7]}}, w_shifted[7:0]};
            end
            LD_H: begin
                w_shifted    = i_data >> {i_off[2:1], 4'b0000};
                o_data       = {{48{i_signed & w_shifted[15]}}, w_shifted[15:0]};
                o_misaligned = i_off[0];
            end
            LD_W: begin
                w_shifted    = i_data >> {i_off[2], 5'b00000};
                o_data       = {{32{i_signed & w_shifted[31]}}, w_shifted[31:0]};
                o_misaligned = |i_off[1:0];
            end
            default: begin
                o_data       = i_data;
                o_misaligned = |i_off;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Brief    : Writeback stage: load alignment, rf write, ecall sequencing, retire count.
// Revision : 1.0
// ============================================================================
module wb_stage
    import wb_pkg::*;
#(
    parameter int REGISTER_WIDTH         = 64,
    parameter int REGISTERNO_WIDTH       = 5,
    parameter int INSTRUCTION_NAME_WIDTH = 96
) (
    input  wire logic  clk,
    input  wire logic  reset,
    wb_stage_if.slave  bus
);

    wb_state_t                         r_state;
    wb_state_t                         w_next;
    logic                              r_ready;
    logic                              r_valid;
    logic [REGISTERNO_WIDTH-1:0]       r_rd;
    logic                              r_update;
    logic                              r_load;
    logic [INSTRUCTION_NAME_WIDTH-1:0] r_op;
    logic [REGISTER_WIDTH-1:0]         r_alu;
    logic [REGISTER_WIDTH-1:0]         r_mdata;
    logic [REGISTER_WIDTH-1:0]         r_ret;
    logic [REGISTER_WIDTH-1:0]         r_count;

    logic                              w_accept;
    logic                              w_is_ecall;
    ld_info_t                          w_ld_info;
    logic [REGISTER_WIDTH-1:0]         w_ld_data;
    logic                              w_ld_mis;
    logic                              w_req;
    logic                              w_flush;

    assign w_accept   = bus.in_enable && r_ready && (bus.in_opcode_name != '0);
    assign w_is_ecall = (bus.in_opcode_name == c_op_ecall);
    assign w_ld_info  = decode_load(r_op);

    load_align u_load_align (
        .i_size       (w_ld_info.size),
        .i_signed     (w_ld_info.is_signed),
        .i_off        (r_alu[2:0]),
        .i_data       (r_mdata),
        .o_data       (w_ld_data),
        .o_misaligned (w_ld_mis)
    );

    always_comb begin
        w_next  = r_state;
        w_req   = 1'b0;
        w_flush = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && w_is_ecall) w_next = SYS_WAIT;
            end
            SYS_WAIT: begin
                w_req = 1'b1;
                if (bus.in_syscall_done) w_next = SYS_RET;
            end
            SYS_RET: begin
                w_flush = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ready  <= 1'b0;
            r_valid  <= 1'b0;
            r_rd     <= '0;
            r_update <= 1'b0;
            r_load   <= 1'b0;
            r_op     <= '0;
            r_alu    <= '0;
            r_mdata  <= '0;
            r_ret    <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_next;
            r_ready  <= (w_next == IDLE);
            r_valid  <= w_accept && !w_is_ecall;
            if (w_accept) begin
                r_rd     <= bus.in_rd_regno;
                r_update <= bus.in_update_rd_bool;
                r_load   <= bus.in_mm_load_bool;
                r_op     <= bus.in_opcode_name;
                r_alu    <= bus.in_alu_result;
                r_mdata  <= bus.in_mdata;
            end
            if (r_state == SYS_WAIT && bus.in_syscall_done) r_ret <= bus.in_syscall_ret;
            // Retirement is counted as the instruction leaves the stage.
            if (r_valid || r_state == SYS_RET) r_count <= r_count + 1'b1;
        end
    end

    always_comb begin
        bus.out_wr_en    = 1'b0;
        bus.out_wr_regno = '0;
        bus.out_wr_data  = '0;
        if (r_state == SYS_RET) begin
            bus.out_wr_en    = 1'b1;
            bus.out_wr_regno = c_a0_regno;
            bus.out_wr_data  = r_ret;
        end else if (r_valid) begin
            bus.out_wr_en    = r_update && (r_rd != '0);
            bus.out_wr_regno = r_rd;
            bus.out_wr_data  = r_load ? w_ld_data : r_alu;
        end
    end

    assign bus.out_ready         = r_ready;
    assign bus.out_misaligned    = r_valid && r_load && w_ld_mis;
    assign bus.out_syscall_req   = w_req;
    assign bus.out_syscall_flush = w_flush;
    assign bus.out_retire_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Brief    : Directed self-checking bench for wb_stage.
// Revision : 1.0
// ============================================================================
module tb_wb_stage;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    wb_stage_if bus ();

    wb_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [95:0] op, input logic [63:0] alu,
                         input logic [63:0] mdata, input logic [4:0] rd,
                         input logic upd, input logic ld);
        bus.in_enable         = en;
        bus.in_opcode_name    = op;
        bus.in_alu_result     = alu;
        bus.in_mdata          = mdata;
        bus.in_rd_regno       = rd;
        bus.in_update_rd_bool = upd;
        bus.in_mm_load_bool   = ld;
    endtask

    initial begin
        logic [95:0] op_lb, op_lbu, op_lw, op_lwu, op_lh, op_ld, op_add, op_ecall;
        op_lb    = {80'h0, "lb"};
        op_lbu   = {72'h0, "lbu"};
        op_lw    = {80'h0, "lw"};
        op_lwu   = {72'h0, "lwu"};
        op_lh    = {80'h0, "lh"};
        op_ld    = {80'h0, "ld"};
        op_add   = {72'h0, "add"};
        op_ecall = {56'h0, "ecall"};
        n_checks = 0;
        n_errors = 0;

        reset = 1'b1;
        drive(1'b0, 96'h0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0);
        bus.in_syscall_done = 1'b0;
        bus.in_syscall_ret  = 64'h0;
        tick();
        tick();
        chk("rst_ready", {63'h0, bus.out_ready}, 64'h0);
        chk("rst_wr_en", {63'h0, bus.out_wr_en}, 64'h0);
        chk("rst_req",   {63'h0, bus.out_syscall_req}, 64'h0);
        chk("rst_count", bus.out_retire_count, 64'h0);

        reset = 1'b0;
        tick();
        chk("ready_after_rst", {63'h0, bus.out_ready}, 64'h1);

        // byte lane 5 holds 0x80
        drive(1'b1, op_lb, 64'h1005, 64'h0000_8000_0000_0000, 5'd5, 1'b1, 1'b1);
        tick();
        chk("lb_wr_en", {63'h0, bus.out_wr_en}, 64'h1);
        chk("lb_regno", {59'h0, bus.out_wr_regno}, 64'd5);
        chk("lb_data",  bus.out_wr_data, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_mis",   {63'h0, bus.out_misaligned}, 64'h0);

        drive(1'b1, op_lbu, 64'h1005, 64'h0000_8000_0000_0000, 5'd5, 1'b1, 1'b1);
        tick();
        chk("lbu_data", bus.out_wr_data, 64'h0000_0000_0000_0080);

        drive(1'b1, op_lw, 64'h2004, 64'h8765_4321_0000_0000, 5'd6, 1'b1, 1'b1);
        tick();
        chk("lw_regno", {59'h0, bus.out_wr_regno}, 64'd6);
        chk("lw_data",  bus.out_wr_data, 64'hFFFF_FFFF_8765_4321);

        drive(1'b1, op_lwu, 64'h2004, 64'h8765_4321_0000_0000, 5'd6, 1'b1, 1'b1);
        tick();
        chk("lwu_data", bus.out_wr_data, 64'h0000_0000_8765_4321);

        drive(1'b1, op_lh, 64'h2003, 64'h0000_0000_9ABC_0000, 5'd7, 1'b1, 1'b1);
        tick();
        chk("lh_mis_wr_en", {63'h0, bus.out_wr_en}, 64'h1);
        chk("lh_mis_flag",  {63'h0, bus.out_misaligned}, 64'h1);
        chk("lh_mis_data",  bus.out_wr_data, 64'hFFFF_FFFF_FFFF_9ABC);

        drive(1'b1, op_ld, 64'h3008, 64'hDEAD_BEEF_0123_4567, 5'd8, 1'b1, 1'b1);
        tick();
        chk("ld_data", bus.out_wr_data, 64'hDEAD_BEEF_0123_4567);
        chk("ld_mis",  {63'h0, bus.out_misaligned}, 64'h0);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, op_add, 64'h7, 64'h0, 5'd0, 1'b1, 1'b0);
            tick();
            chk("add_x0_wr_en", {63'h0, bus.out_wr_en}, 64'h0);
            chk("add_x0_ready", {63'h0, bus.out_ready}, 64'h1);
        end
        drive(1'b0, 96'h0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("count_after_9", bus.out_retire_count, 64'd9);

        // ecall, then an add held by the memory stage while stalled
        drive(1'b1, op_ecall, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, op_add, 64'h55, 64'h0, 5'd3, 1'b1, 1'b0);
        chk("ecall_no_wr", {63'h0, bus.out_wr_en}, 64'h0);
        for (int i = 1; i <= 4; i++) begin
            chk("wait_req",   {63'h0, bus.out_syscall_req}, 64'h1);
            chk("wait_ready", {63'h0, bus.out_ready}, 64'h0);
            chk("wait_wr_en", {63'h0, bus.out_wr_en}, 64'h0);
            if (i == 4) begin
                bus.in_syscall_done = 1'b1;
                bus.in_syscall_ret  = 64'h2A;
            end
            tick();
        end
        bus.in_syscall_done = 1'b0;
        bus.in_syscall_ret  = 64'hFFFF;
        chk("ret_wr_en", {63'h0, bus.out_wr_en}, 64'h1);
        chk("ret_regno", {59'h0, bus.out_wr_regno}, 64'd10);
        chk("ret_data",  bus.out_wr_data, 64'h2A);
        chk("ret_flush", {63'h0, bus.out_syscall_flush}, 64'h1);
        chk("ret_ready", {63'h0, bus.out_ready}, 64'h0);
        chk("ret_req",   {63'h0, bus.out_syscall_req}, 64'h0);
        tick();
        chk("idle_ready", {63'h0, bus.out_ready}, 64'h1);
        chk("idle_flush", {63'h0, bus.out_syscall_flush}, 64'h0);
        chk("idle_wr_en", {63'h0, bus.out_wr_en}, 64'h0);
        chk("idle_count", bus.out_retire_count, 64'd10);
        tick();
        drive(1'b0, 96'h0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0);
        chk("held_wr_en",  {63'h0, bus.out_wr_en}, 64'h1);
        chk("held_regno",  {59'h0, bus.out_wr_regno}, 64'd3);
        chk("held_data",   bus.out_wr_data, 64'h55);
        tick();
        chk("count_after_held", bus.out_retire_count, 64'd11);

        // reset while waiting on the handler
        drive(1'b1, op_ecall, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 96'h0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("pre_rst_req", {63'h0, bus.out_syscall_req}, 64'h1);
        reset = 1'b1;
        tick();
        chk("mid_rst_req",   {63'h0, bus.out_syscall_req}, 64'h0);
        chk("mid_rst_flush", {63'h0, bus.out_syscall_flush}, 64'h0);
        chk("mid_rst_count", bus.out_retire_count, 64'h0);
        reset = 1'b0;
        bus.in_syscall_done = 1'b1;
        bus.in_syscall_ret  = 64'h77;
        tick();
        bus.in_syscall_done = 1'b0;
        chk("late_done_req",   {63'h0, bus.out_syscall_req}, 64'h0);
        chk("late_done_ready", {63'h0, bus.out_ready}, 64'h1);
        tick();
        chk("late_done_wr_en", {63'h0, bus.out_wr_en}, 64'h0);
        chk("late_done_flush", {63'h0, bus.out_syscall_flush}, 64'h0);

        // stray done in IDLE plus an enabled bubble
        drive(1'b1, 96'h0, 64'h99, 64'h0, 5'd4, 1'b1, 1'b0);
        bus.in_syscall_done = 1'b1;
        tick();
        bus.in_syscall_done = 1'b0;
        drive(1'b0, 96'h0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0);
        chk("bubble_wr_en", {63'h0, bus.out_wr_en}, 64'h0);
        chk("bubble_req",   {63'h0, bus.out_syscall_req}, 64'h0);
        chk("bubble_ready", {63'h0, bus.out_ready}, 64'h1);
        tick();
        chk("bubble_count", bus.out_retire_count, 64'h0);
        chk("bubble_flush", {63'h0, bus.out_syscall_flush}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
